// File: rtl/led_rng_display.sv
// Random-pattern LED driver: buffers RNG words and, once per display period,
// shows a fresh on/off or PWM-brightness pattern drawn from the buffered bits.
module led_rng_display #(
  parameter int unsigned NUM_LEDS   = 4,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned PERIOD     = 50_000_000,
  parameter int unsigned PWM_BITS   = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  mode,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_LEDS-1:0]   leds,
  output logic                  underrun
);

  localparam int unsigned CNT_W    = $clog2(WORD_WIDTH + 1);
  localparam int unsigned PER_W    = $clog2(PERIOD);
  localparam int unsigned NEED_OFF = NUM_LEDS;
  localparam int unsigned NEED_PWM = NUM_LEDS * PWM_BITS;

  logic [PER_W-1:0]                   period_cnt;
  logic [PWM_BITS-1:0]                pwm_cnt;
  logic [WORD_WIDTH-1:0]              buffer;
  logic [WORD_WIDTH-1:0]              shifted;
  logic [CNT_W-1:0]                   count;
  logic [CNT_W-1:0]                   need;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0]  duty_next;
  logic [NUM_LEDS-1:0]                leds_next;
  logic                               pending;
  logic                               applied_mode;
  logic                               tick;
  logic                               have_bits;
  logic                               load;
  logic                               consume;

  assign need      = mode ? CNT_W'(NEED_PWM) : CNT_W'(NEED_OFF);
  assign tick      = (period_cnt == PER_W'(PERIOD - 1));
  assign have_bits = (count >= need);
  assign in_ready  = !have_bits;
  assign load      = in_valid && in_ready;
  assign consume   = (tick || pending) && have_bits;
  assign shifted   = mode ? (buffer >> NEED_PWM) : (buffer >> NEED_OFF);

  // Field extraction for the next pattern; on/off fields are one bit wide.
  always_comb begin
    duty_next = duty;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (mode) duty_next[i] = buffer[i*PWM_BITS +: PWM_BITS];
      else      duty_next[i] = PWM_BITS'(buffer[i]);
    end
  end

  always_comb begin
    leds_next = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      leds_next[i] = applied_mode ? (duty[i] > pwm_cnt) : duty[i][0];
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      period_cnt   <= '0;
      pwm_cnt      <= '0;
      buffer       <= '0;
      count        <= '0;
      duty         <= '0;
      pending      <= 1'b0;
      applied_mode <= 1'b0;
      leds         <= '0;
      underrun     <= 1'b0;
    end else begin
      period_cnt <= tick ? '0 : PER_W'(period_cnt + 1'b1);
      pwm_cnt    <= PWM_BITS'(pwm_cnt + 1'b1);
      leds       <= leds_next;
      underrun   <= tick && pending && !have_bits;

      // Load and consume never coincide: their count conditions are disjoint.
      if (load) begin
        buffer <= in_data;
        count  <= CNT_W'(WORD_WIDTH);
      end else if (consume) begin
        buffer       <= shifted;
        count        <= CNT_W'(count - need);
        duty         <= duty_next;
        applied_mode <= mode;
      end

      // A tick landing on the consume of a pending update is absorbed.
      if (consume)                 pending <= 1'b0;
      else if (tick && !have_bits) pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_led_rng_display.sv
// Scoreboard bench for led_rng_display: stimulus queues cycle-stamped
// expectations, a monitor compares them against the outputs.
module tb_led_rng_display;

  logic        clock = 1'b0;
  logic        clear;
  logic        mode;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  leds;
  logic        underrun;

  led_rng_display #(
    .NUM_LEDS  (4),
    .WORD_WIDTH(32),
    .PERIOD    (8),
    .PWM_BITS  (4)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .mode    (mode),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .leds    (leds),
    .underrun(underrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t aq[$];
  int   cyc      = 0;
  int   rel0     = 0;
  int   checks   = 0;
  int   failures = 0;
  logic chk_tgl  = 1'b0;
  logic tally_en = 1'b0;
  int   hi [4]     = '{0, 0, 0, 0};
  int   duty_m [4] = '{0, 8, 0, 15};

  always @(posedge clock) cyc <= cyc + 1;

  // sig: 0 leds, 1 in_ready, 2 underrun, 3..6 high-cycle tally of LED0..3.
  task automatic compare(input exp_t e);
    logic [31:0] act;
    case (e.sig)
      0:       act = 32'(leds);
      1:       act = 32'(in_ready);
      2:       act = 32'(underrun);
      default: act = 32'(hi[e.sig-3]);
    endcase
    checks++;
    if (act !== e.exp || (e.cyc >= 0 && e.cyc != cyc)) begin
      failures++;
      $display("FAIL %s at cycle %0d (rel %0d): got %0h, expected %0h",
               e.tag, cyc, cyc - rel0, act, e.exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock or chk_tgl);
      while (aq.size() > 0) compare(aq.pop_front());
      if (clock == 1'b0) begin
        if (tally_en)
          for (int i = 0; i < 4; i++) hi[i] += int'(leds[i]);
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].cyc <= cyc) begin
            compare(sb[i]);
            sb.delete(i);
          end
        end
      end
    end
  end

  task automatic goto(input int r);
    while (cyc < rel0 + r) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic exp_at(input int r, input int sig, input logic [31:0] v, input string tag);
    exp_t e;
    e.cyc = rel0 + r;
    e.sig = sig;
    e.exp = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic exp_now(input int sig, input logic [31:0] v, input string tag);
    exp_t e;
    e.cyc = -1;
    e.sig = sig;
    e.exp = v;
    e.tag = tag;
    aq.push_back(e);
  endtask

  task automatic start_phase();
    clear    = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    clear = 1'b0;
    rel0  = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    clear    = 1'b1;
    mode     = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset, starvation, recovery and backpressure in on/off mode.
    start_phase();
    exp_at(0,  0, 0,    "rst_leds");
    exp_at(0,  1, 1,    "rst_in_ready");
    exp_at(0,  2, 0,    "rst_underrun");
    exp_at(8,  2, 0,    "tick1_no_underrun");
    exp_at(15, 2, 0,    "pre_tick2_underrun");
    exp_at(16, 2, 1,    "tick2_underrun");
    exp_at(16, 0, 0,    "starved_leds");
    exp_at(17, 2, 0,    "underrun_one_cycle");
    exp_at(21, 1, 0,    "ready_after_load");
    exp_at(22, 0, 0,    "leds_before_update");
    exp_at(23, 0, 4'hF, "pending_update_leds");
    exp_at(24, 0, 4'hF, "pending_update_hold");
    exp_at(24, 2, 0,    "absorbed_tick_no_underrun");
    exp_at(25, 0, 0,    "second_field_leds");
    exp_at(33, 0, 0,    "backpressure_third_field");
    exp_at(71, 1, 0,    "ready_before_last_consume");
    exp_at(72, 1, 1,    "ready_after_eight_consumes");
    exp_at(73, 1, 0,    "held_word_accepted");
    exp_at(81, 0, 0,    "held_word_field0");
    exp_at(89, 0, 4'hA, "held_word_field1");
    goto(20);
    in_valid = 1'b1;
    in_data  = 32'h0000000F;
    goto(21);
    in_data  = 32'h555555A0;
    goto(73);
    in_valid = 1'b0;
    goto(90);

    // On/off mode with a word buffered before the first tick.
    start_phase();
    exp_at(3,  1, 0,    "onoff_ready_low");
    exp_at(8,  0, 0,    "onoff_before_tick");
    exp_at(9,  0, 4'h5, "onoff_tick1");
    exp_at(16, 0, 4'h5, "onoff_tick1_hold");
    exp_at(17, 0, 4'hA, "onoff_tick2");
    goto(2);
    in_valid = 1'b1;
    in_data  = 32'h000000A5;
    goto(3);
    in_valid = 1'b0;
    goto(18);

    // PWM brightness over one full PWM cycle.
    mode = 1'b1;
    start_phase();
    exp_at(3,  1, 0, "pwm_ready_full");
    exp_at(8,  0, 0, "pwm_before_tick");
    exp_at(8,  1, 0, "pwm_ready_half");
    exp_at(15, 1, 0, "pwm_ready_before_2nd");
    exp_at(16, 1, 1, "pwm_ready_empty");
    for (int c = 9; c <= 24; c++) begin
      logic [3:0] v;
      int p;
      p = (c - 1) % 16;
      for (int i = 0; i < 4; i++) v[i] = (duty_m[i] > p);
      exp_at(c, 0, 32'(v), "pwm_leds");
    end
    exp_at(25, 3, 0,  "pwm_led0_high");
    exp_at(25, 4, 8,  "pwm_led1_high");
    exp_at(25, 5, 0,  "pwm_led2_high");
    exp_at(25, 6, 15, "pwm_led3_high");
    goto(2);
    in_valid = 1'b1;
    in_data  = 32'hF080F080;
    goto(3);
    in_valid = 1'b0;
    goto(9);
    tally_en = 1'b1;
    goto(25);
    tally_en = 1'b0;
    goto(26);

    // Asynchronous clear in the middle of a PWM pattern, then restart.
    start_phase();
    goto(2);
    in_valid = 1'b1;
    in_data  = 32'hF080F080;
    goto(3);
    in_valid = 1'b0;
    goto(12);
    exp_now(0, 4'h8, "mid_leds_before_clear");
    exp_now(1, 0,    "mid_ready_before_clear");
    chk_tgl = ~chk_tgl;
    clear = 1'b1;
    #1;
    exp_now(0, 0, "async_clear_leds");
    exp_now(1, 1, "async_clear_ready");
    exp_now(2, 0, "async_clear_underrun");
    chk_tgl = ~chk_tgl;
    repeat (2) @(posedge clock);
    #2;
    clear = 1'b0;
    rel0  = cyc;
    exp_at(0,  0, 0, "restart_leds");
    exp_at(0,  1, 1, "restart_ready");
    exp_at(9,  0, 0, "restart_leds_starved");
    exp_at(15, 2, 0, "restart_pre_tick2");
    exp_at(16, 2, 1, "restart_tick2_underrun");
    exp_at(17, 2, 0, "restart_underrun_end");
    goto(19);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
